// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding request, 2-entry {pc, instr} queue.
// Optional retired-fetch counter under `FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WAIT_DROP
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] pc0_q, pc0_d;
  logic [31:0] pc1_q, pc1_d;
  logic [31:0] ins0_q, ins0_d;
  logic [31:0] ins1_q, ins1_d;
  logic [1:0]  count_q, count_d;

  logic [31:0] rd_pc;
  logic        issue;
  logic        push;
  logic        pop;

  assign rd_pc = {redirect_pc[31:2], 2'b00};

  // A request only leaves from IDLE with a free slot left for its reply;
  // rst_n gates it so nothing is requested while reset is held.
  assign issue = rst_n
              && (state_q == S_IDLE)
              && !redirect
              && (count_q != 2'd2);

  assign push = (state_q == S_WAIT) && imem_rvalid && !redirect;
  assign pop  = ir_valid && ir_ready && !redirect;

  assign imem_req  = issue;
  assign imem_addr = issue ? pc_q : 32'h0;

  assign ir_valid = (count_q != 2'd0);
  assign ir       = ir_valid ? ins0_q : NOP;
  assign ir_pc    = pc0_q;

  // Request FSM: tracks the single outstanding fetch and drops stale replies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect) begin
            pc_q <= rd_pc;
          end else if (issue) begin
            state_q  <= S_WAIT;
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc_q    <= rd_pc;
            state_q <= imem_rvalid ? S_IDLE : S_WAIT_DROP;
          end else if (imem_rvalid) begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT_DROP: begin
          if (redirect) begin
            pc_q <= rd_pc;
          end
          // The stale reply retires the drop even if a redirect coincides.
          if (imem_rvalid) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Shift queue next state: entry 0 is always the head shown on ir.
  always_comb begin
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    ins0_d  = ins0_q;
    ins1_d  = ins1_q;
    count_d = count_q;
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_d  = req_pc_q;
            ins0_d = imem_rdata;
          end else begin
            pc1_d  = req_pc_q;
            ins1_d = imem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          pc0_d   = pc1_q;
          ins0_d  = ins1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            pc0_d  = req_pc_q;
            ins0_d = imem_rdata;
          end else begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = req_pc_q;
            ins1_d = imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc0_q   <= 32'h0;
      pc1_q   <= 32'h0;
      ins0_q  <= NOP;
      ins1_q  <= NOP;
      count_q <= 2'd0;
    end else begin
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      ins0_q  <= ins0_d;
      ins1_q  <= ins1_d;
      count_q <= count_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;

  // Count every handshake the consumer completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= 32'h0;
    end else if (ir_valid && ir_ready) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_fetched = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder plus an in-order pc stream model.
// Define FETCH_PERF_CNT_EN to also exercise perf_fetched.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
`endif

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus controls
  logic        drv_ready = 1'b0;
  logic        drv_redirect = 1'b0;
  logic [31:0] drv_rpc = 32'h0;
  logic        inject_stale = 1'b0;
  int          mem_lat = 1;

  // memory model
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;

  // stream model
  logic [31:0] exp_pc = RESET_PC;
  int          n_deliv = 0;

  // samples
  logic        s_req, s_valid, s_rvalid;
  logic [31:0] s_addr, s_ir, s_pc;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
  endfunction

  // One clock cycle: drive at negedge, sample 1 time unit later.
  task automatic cycle();
    logic resp;
    @(negedge clk);
    resp        = mem_busy && (mem_cnt == 0);
    imem_rvalid = resp || inject_stale;
    if (inject_stale)
      imem_rdata = 32'hDEAD_BEEF;
    else if (resp)
      imem_rdata = mword(mem_addr);
    else
      imem_rdata = $urandom;
    ir_ready    = drv_ready;
    redirect    = drv_redirect;
    redirect_pc = drv_rpc;
    #1;
    s_req    = imem_req;
    s_addr   = imem_addr;
    s_valid  = ir_valid;
    s_ir     = ir;
    s_pc     = ir_pc;
    s_rvalid = imem_rvalid;
    if (resp)
      mem_busy = 1'b0;
    else if (mem_busy)
      mem_cnt--;
    if (s_req) begin
      n_checks++;
      if (s_addr[1:0] !== 2'b00 || mem_busy) begin
        n_fail++;
        $display("FAIL req_legal: addr %h busy %0b, required aligned and idle",
                 s_addr, mem_busy);
      end
      mem_busy = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = mem_lat - 1;
    end
    if (s_valid && drv_ready && !drv_redirect) begin
      n_checks++;
      if (s_pc !== exp_pc || s_ir !== mword(exp_pc)) begin
        n_fail++;
        $display("FAIL deliver: pc %h ir %h, required pc %h ir %h",
                 s_pc, s_ir, exp_pc, mword(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (drv_redirect)
      exp_pc = {drv_rpc[31:2], 2'b00};
  endtask

  task automatic clear_drv();
    drv_ready    = 1'b0;
    drv_redirect = 1'b0;
    drv_rpc      = 32'h0;
    inject_stale = 1'b0;
    mem_lat      = 1;
  endtask

  task automatic assert_reset();
    #2;
    rst_n       = 1'b0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    mem_busy = 1'b0;
    exp_pc   = RESET_PC;
    rst_n    = 1'b1;
  endtask

  task automatic fresh();
    clear_drv();
    assert_reset();
    release_reset();
  endtask

  task automatic test_reset();
    clear_drv();
    release_reset();
    mem_lat   = 3;
    drv_ready = 1'b1;
    cycle();
    cycle();
    assert_reset();
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_req: req %b addr %h, required 0 0",
               imem_req, imem_addr);
    end
    n_checks++;
    if (ir_valid !== 1'b0 || ir !== NOP || ir_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_ir: valid %b ir %h pc %h, required 0 %h 0",
               ir_valid, ir, ir_pc, NOP);
    end
    release_reset();
    inject_stale = 1'b1;
    cycle();
    inject_stale = 1'b0;
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: req %b addr %h, required 1 %h",
               s_req, s_addr, RESET_PC);
    end
    for (int i = 0; i < 6; i++) cycle();
    n_checks++;
    if (n_deliv == 0) begin
      n_fail++;
      $display("FAIL post_rst_deliv: got %0d, required >0", n_deliv);
    end
  endtask

  task automatic test_stream();
    int idx[4];
    logic [31:0] pcs[4];
    int k;
    fresh();
    drv_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_valid && k < 4) begin
        idx[k] = i;
        pcs[k] = s_pc;
        k++;
      end
    end
    n_checks++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL stream_cnt: got %0d, required 4", k);
    end else begin
      n_checks++;
      if (idx[0] != 2) begin
        n_fail++;
        $display("FAIL stream_first: cycle %0d, required 2", idx[0]);
      end
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (pcs[j] !== 32'(4 * j) || (j > 0 && idx[j] != idx[j-1] + 2)) begin
          n_fail++;
          $display("FAIL stream_%0d: pc %h cyc %0d, required pc %h every 2",
                   j, pcs[j], idx[j], 32'(4 * j));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int reqs;
    fresh();
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_req) reqs++;
    end
    n_checks++;
    if (reqs != 2 || s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_reqs: reqs %0d last %b, required 2 0", reqs, s_req);
    end
    n_checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_head: valid %b pc %h, required 1 0", s_valid, s_pc);
    end
    drv_ready = 1'b1;
    cycle();
    n_checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_pop0: valid %b pc %h, required 1 0", s_valid, s_pc);
    end
    cycle();
    n_checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL bp_pop1: valid %b pc %h, required 1 4", s_valid, s_pc);
    end
  endtask

  task automatic test_redirect_wait();
    int  at;
    logic seen;
    fresh();
    mem_lat   = 3;
    drv_ready = 1'b1;
    cycle();
    drv_redirect = 1'b1;
    drv_rpc      = 32'h0000_0102;
    cycle();
    drv_redirect = 1'b0;
    at   = -1;
    seen = 1'b0;
    for (int i = 2; i < 12 && at < 0; i++) begin
      cycle();
      if (s_req) at = i;
    end
    n_checks++;
    if (at != 4 || s_addr !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL rdw_req: cyc %0d addr %h, required 4 00000100",
               at, s_addr);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = s_valid;
    end
    n_checks++;
    if (!seen || s_pc !== 32'h100 || s_ir !== mword(32'h100)) begin
      n_fail++;
      $display("FAIL rdw_ir: valid %b pc %h, required 1 00000100",
               seen, s_pc);
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    fresh();
    cycle();
    cycle();
    cycle();
    drv_ready    = 1'b1;
    drv_redirect = 1'b1;
    drv_rpc      = 32'h0000_0200;
    cycle();
    drv_redirect = 1'b0;
    n_checks++;
    if (s_rvalid !== 1'b1 || s_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rrp_setup: rvalid %b valid %b, required 1 1",
               s_rvalid, s_valid);
    end
    cycle();
    n_checks++;
    if (s_valid !== 1'b0 || s_ir !== NOP) begin
      n_fail++;
      $display("FAIL rrp_flush: valid %b ir %h, required 0 %h",
               s_valid, s_ir, NOP);
    end
    for (int i = 0; i < 8; i++) cycle();
  endtask

  task automatic test_wrap();
    int  n;
    fresh();
    drv_ready    = 1'b1;
    drv_redirect = 1'b1;
    drv_rpc      = 32'hFFFF_FFFF;
    cycle();
    drv_redirect = 1'b0;
    n_checks++;
    if (s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_sup: req %b, required 0", s_req);
    end
    cycle();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_top: req %b addr %h, required 1 fffffffc",
               s_req, s_addr);
    end
    n = 0;
    do begin
      cycle();
      n++;
    end while (!s_req && n < 10);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_zero: req %b addr %h, required 1 0", s_req, s_addr);
    end
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic test_random();
    int d0;
    fresh();
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      mem_lat      = $urandom_range(1, 4);
      drv_ready    = ($urandom % 4) != 0;
      drv_redirect = ($urandom % 25) == 0;
      drv_rpc      = $urandom;
      cycle();
    end
    clear_drv();
    n_checks++;
    if (n_deliv - d0 < 100) begin
      n_fail++;
      $display("FAIL rand_progress: got %0d, required >=100", n_deliv - d0);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    int got;
    fresh();
    drv_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 5; i++) begin
      cycle();
      if (s_valid) got++;
    end
    drv_ready = 1'b0;
    cycle();
    n_checks++;
    if (perf_fetched !== 32'd5) begin
      n_fail++;
      $display("FAIL perf_5: got %0d, required 5", perf_fetched);
    end
    assert_reset();
    n_checks++;
    if (perf_fetched !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_rst: got %0d, required 0", perf_fetched);
    end
    release_reset();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
